// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the icache and dcache
// controllers, tracks which side owns each outstanding load tag, and routes
// returning data back to that owner. A starvation counter lets the icache
// win after MAX_WAIT consecutive lost arbitration cycles.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int NUM_TAGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  BUS_COMMAND  Icache_command,
    input  logic [63:0] Icache_addr,
    input  BUS_COMMAND  Dcache_command,
    input  logic [63:0] Dcache_addr,
    input  logic [63:0] Dcache_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output BUS_COMMAND  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  Imem_response,
    output logic [3:0]  Imem_tag,
    output logic [63:0] Imem_data,
    output logic [3:0]  Dmem_response,
    output logic [3:0]  Dmem_tag,
    output logic [63:0] Dmem_data,
    output logic [4:0]  outstanding_count,
    output logic        tag_error
);

    localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

    // Tag table: valid marks an outstanding load, owner says who gets it back
    // (0 = icache, 1 = dcache).
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;
    logic [2:0]          wait_cnt_q, wait_cnt_d;
    logic                tag_error_q, tag_error_d;
    logic [4:0]          count_q, count_d;

    logic       icache_req, dcache_req;
    logic       icache_wins, dcache_wins;
    logic       load_accept;
    logic       tag_nz, ret_hit, ret_owner;
    BUS_COMMAND win_cmd;

    // Saturating increment of the starvation counter.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == WAIT_MAX) ? v : v + 3'd1;
    endfunction

    // Number of set bits in the valid vector.
    function automatic logic [4:0] popcount(input logic [NUM_TAGS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

    // Arbitration: dcache has priority unless the icache has starved long enough.
    always_comb begin
        icache_req  = (Icache_command != BUS_NONE);
        dcache_req  = (Dcache_command != BUS_NONE);
        icache_wins = icache_req && (!dcache_req || (wait_cnt_q == WAIT_MAX));
        dcache_wins = dcache_req && !icache_wins;
        win_cmd     = BUS_NONE;
        if (icache_wins) begin
            win_cmd = Icache_command;
        end else if (dcache_wins) begin
            win_cmd = Dcache_command;
        end
        load_accept = !reset && (win_cmd == BUS_LOAD) && (mem2proc_response != 4'd0);
    end

    // Forward the winner's request to memory and its accept tag back to it only.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        Imem_response    = '0;
        Dmem_response    = '0;
        if (!reset) begin
            proc2mem_command = win_cmd;
            if (icache_wins) begin
                proc2mem_addr = Icache_addr;
                Imem_response = mem2proc_response;
            end else if (dcache_wins) begin
                proc2mem_addr = Dcache_addr;
                proc2mem_data = Dcache_data;
                Dmem_response = mem2proc_response;
            end
        end
    end

    // Route a returning load to the side that owns its tag; unknown tags go nowhere.
    always_comb begin
        tag_nz    = (mem2proc_tag != 4'd0);
        ret_hit   = tag_nz && valid_q[mem2proc_tag];
        ret_owner = owner_q[mem2proc_tag];
        Imem_tag  = '0;
        Imem_data = '0;
        Dmem_tag  = '0;
        Dmem_data = '0;
        if (!reset && ret_hit) begin
            if (ret_owner) begin
                Dmem_tag  = mem2proc_tag;
                Dmem_data = mem2proc_data;
            end else begin
                Imem_tag  = mem2proc_tag;
                Imem_data = mem2proc_data;
            end
        end
        outstanding_count = reset ? 5'd0 : count_q;
        tag_error         = tag_error_q;
    end

    // Next state: retire first, then allocate so a same-tag allocation wins.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit) begin
            valid_d[mem2proc_tag] = 1'b0;
        end
        if (load_accept) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = dcache_wins;
        end
        wait_cnt_d = wait_cnt_q;
        if (!icache_req) begin
            wait_cnt_d = 3'd0;
        end else if (icache_wins) begin
            if (mem2proc_response != 4'd0) begin
                wait_cnt_d = 3'd0;
            end
        end else begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
        tag_error_d = tag_error_q | (tag_nz && !valid_q[mem2proc_tag]);
        count_d     = popcount(valid_d);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            wait_cnt_q  <= 3'd0;
            tag_error_q <= 1'b0;
            count_q     <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            wait_cnt_q  <= wait_cnt_d;
            tag_error_q <= tag_error_d;
            count_q     <= count_d;
        end
    end

    // Owner bits only matter while valid is set, so they carry no reset.
    always_ff @(posedge clock) begin
        owner_q <= owner_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: accepted loads push their expected
// owner/tag/data onto a scoreboard; returns pop and compare the routed outputs.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock, reset;
    BUS_COMMAND  Icache_command, Dcache_command, proc2mem_command;
    logic [63:0] Icache_addr, Dcache_addr, Dcache_data, mem2proc_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] proc2mem_addr, proc2mem_data, Imem_data, Dmem_data;
    logic [3:0]  Imem_response, Imem_tag, Dmem_response, Dmem_tag;
    logic [4:0]  outstanding_count;
    logic        tag_error;

    typedef struct {
        logic [3:0]  tag;
        logic        owner;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [3:0] rej_resp [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd9, 4'd10};
    logic [6:0] rej_iwin = 7'b0110000;
    logic [5:0] stv_iwin = 6'b010000;

    mem_arbiter #(.MAX_WAIT(4), .NUM_TAGS(16)) dut (
        .clock(clock), .reset(reset),
        .Icache_command(Icache_command), .Icache_addr(Icache_addr),
        .Dcache_command(Dcache_command), .Dcache_addr(Dcache_addr), .Dcache_data(Dcache_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .Imem_response(Imem_response), .Imem_tag(Imem_tag), .Imem_data(Imem_data),
        .Dmem_response(Dmem_response), .Dmem_tag(Dmem_tag), .Dmem_data(Dmem_data),
        .outstanding_count(outstanding_count), .tag_error(tag_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        Icache_command    = BUS_NONE;
        Dcache_command    = BUS_NONE;
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd0;
        mem2proc_data     = 64'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        Icache_addr = 64'd0; Dcache_addr = 64'd0; Dcache_data = 64'd0;
        step(); step();
        Dcache_command = BUS_LOAD; Dcache_addr = 64'h40; mem2proc_response = 4'd3; mem2proc_tag = 4'd3;
        #1;
        n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rst_cmd got %0d want %0d", proc2mem_command, BUS_NONE); end
        n_cmp++; if (Dmem_response !== 4'd0) begin n_fail++; $display("FAIL rst_dresp got %0d want 0", Dmem_response); end
        n_cmp++; if (Dmem_tag !== 4'd0 || Imem_tag !== 4'd0) begin n_fail++; $display("FAIL rst_tags got %0d/%0d want 0/0", Imem_tag, Dmem_tag); end
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", outstanding_count); end
        step();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL rst_tagerr got %0b want 0", tag_error); end
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rst_count2 got %0d want 0", outstanding_count); end
        n_cmp++; if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 64'd0 || proc2mem_data !== 64'd0) begin n_fail++; $display("FAIL idle_bus got %0d/%h/%h want 0/0/0", proc2mem_command, proc2mem_addr, proc2mem_data); end
    endtask

    task automatic test_dcache_load();
        exp_t e;
        Dcache_command = BUS_LOAD; Dcache_addr = 64'h1000; Dcache_data = 64'h55; mem2proc_response = 4'd3;
        #1;
        n_cmp++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h1000) begin n_fail++; $display("FAIL dld_fwd got %0d/%h want 1/1000", proc2mem_command, proc2mem_addr); end
        n_cmp++; if (proc2mem_data !== 64'h55) begin n_fail++; $display("FAIL dld_data got %h want 55", proc2mem_data); end
        n_cmp++; if (Dmem_response !== 4'd3 || Imem_response !== 4'd0) begin n_fail++; $display("FAIL dld_resp got I%0d D%0d want I0 D3", Imem_response, Dmem_response); end
        exp_q.push_back('{4'd3, 1'b1, 64'hDEAD});
        step();
        idle();
        n_cmp++; if (outstanding_count !== 5'd1) begin n_fail++; $display("FAIL dld_count1 got %0d want 1", outstanding_count); end
        step();
        e = exp_q.pop_front();
        mem2proc_tag = e.tag; mem2proc_data = e.data;
        #1;
        n_cmp++; if (Dmem_tag !== e.tag || Dmem_data !== e.data) begin n_fail++; $display("FAIL dld_ret got %0d/%h want %0d/%h", Dmem_tag, Dmem_data, e.tag, e.data); end
        n_cmp++; if (Imem_tag !== 4'd0 || Imem_data !== 64'd0) begin n_fail++; $display("FAIL dld_iside got %0d/%h want 0/0", Imem_tag, Imem_data); end
        step();
        idle();
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL dld_count0 got %0d want 0", outstanding_count); end
        n_cmp++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL dld_tagerr got %0b want 0", tag_error); end
    endtask

    task automatic test_starvation();
        exp_t e;
        logic [3:0] t;
        logic iw;
        Icache_addr = 64'h2000; Dcache_addr = 64'h3000;
        for (int k = 0; k < 6; k++) begin
            t = 4'(k + 1);
            iw = stv_iwin[k];
            Icache_command = BUS_LOAD; Dcache_command = BUS_LOAD; mem2proc_response = t;
            #1;
            n_cmp++; if (Imem_response !== (iw ? t : 4'd0) || Dmem_response !== (iw ? 4'd0 : t)) begin n_fail++; $display("FAIL stv_resp%0d got I%0d D%0d want I%0d D%0d", k, Imem_response, Dmem_response, iw ? t : 4'd0, iw ? 4'd0 : t); end
            n_cmp++; if (proc2mem_addr !== (iw ? 64'h2000 : 64'h3000)) begin n_fail++; $display("FAIL stv_addr%0d got %h want %h", k, proc2mem_addr, iw ? 64'h2000 : 64'h3000); end
            exp_q.push_back('{t, !iw, 64'hA000_0000 + 64'(k)});
            step();
        end
        idle();
        n_cmp++; if (outstanding_count !== 5'd6) begin n_fail++; $display("FAIL stv_count got %0d want 6", outstanding_count); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            mem2proc_tag = e.tag; mem2proc_data = e.data;
            #1;
            n_cmp++; if (Imem_tag !== (e.owner ? 4'd0 : e.tag) || Dmem_tag !== (e.owner ? e.tag : 4'd0)) begin n_fail++; $display("FAIL stv_rtag%0d got I%0d D%0d want owner %0b tag %0d", k, Imem_tag, Dmem_tag, e.owner, e.tag); end
            n_cmp++; if ((e.owner ? Dmem_data : Imem_data) !== e.data) begin n_fail++; $display("FAIL stv_rdata%0d got %h/%h want %h", k, Imem_data, Dmem_data, e.data); end
            step();
        end
        idle();
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL stv_count0 got %0d want 0", outstanding_count); end
    endtask

    task automatic test_starve_reject();
        exp_t e;
        logic [3:0] r;
        logic iw;
        for (int k = 0; k < 7; k++) begin
            r = rej_resp[k];
            iw = rej_iwin[k];
            Icache_command = BUS_LOAD; Dcache_command = BUS_LOAD; mem2proc_response = r;
            #1;
            n_cmp++; if (Imem_response !== (iw ? r : 4'd0) || Dmem_response !== (iw ? 4'd0 : r)) begin n_fail++; $display("FAIL rej_resp%0d got I%0d D%0d want I%0d D%0d", k, Imem_response, Dmem_response, iw ? r : 4'd0, iw ? 4'd0 : r); end
            n_cmp++; if (proc2mem_addr !== (iw ? 64'h2000 : 64'h3000)) begin n_fail++; $display("FAIL rej_addr%0d got %h want %h", k, proc2mem_addr, iw ? 64'h2000 : 64'h3000); end
            if (r != 4'd0) exp_q.push_back('{r, !iw, 64'hB000_0000 + 64'(k)});
            step();
        end
        idle();
        n_cmp++; if (outstanding_count !== 5'd6) begin n_fail++; $display("FAIL rej_count got %0d want 6", outstanding_count); end
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            mem2proc_tag = e.tag; mem2proc_data = e.data;
            #1;
            n_cmp++; if (Imem_tag !== (e.owner ? 4'd0 : e.tag) || Dmem_tag !== (e.owner ? e.tag : 4'd0)) begin n_fail++; $display("FAIL rej_rtag%0d got I%0d D%0d want owner %0b tag %0d", k, Imem_tag, Dmem_tag, e.owner, e.tag); end
            step();
        end
        idle();
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rej_count0 got %0d want 0", outstanding_count); end
    endtask

    task automatic test_store_tag_error();
        Dcache_command = BUS_STORE; Dcache_addr = 64'h4000; Dcache_data = 64'hCAFE; mem2proc_response = 4'd5;
        #1;
        n_cmp++; if (proc2mem_command !== BUS_STORE || proc2mem_data !== 64'hCAFE) begin n_fail++; $display("FAIL st_fwd got %0d/%h want 2/cafe", proc2mem_command, proc2mem_data); end
        n_cmp++; if (Dmem_response !== 4'd5) begin n_fail++; $display("FAIL st_resp got %0d want 5", Dmem_response); end
        step();
        idle();
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL st_count got %0d want 0", outstanding_count); end
        mem2proc_tag = 4'd5; mem2proc_data = 64'h1234;
        #1;
        n_cmp++; if (Imem_tag !== 4'd0 || Dmem_tag !== 4'd0 || Imem_data !== 64'd0 || Dmem_data !== 64'd0) begin n_fail++; $display("FAIL st_ret got I%0d D%0d want 0/0", Imem_tag, Dmem_tag); end
        step();
        idle();
        n_cmp++; if (tag_error !== 1'b1) begin n_fail++; $display("FAIL st_tagerr got %0b want 1", tag_error); end
        step();
        n_cmp++; if (tag_error !== 1'b1) begin n_fail++; $display("FAIL st_sticky got %0b want 1", tag_error); end
    endtask

    task automatic test_retire_alloc();
        exp_t e;
        Icache_command = BUS_LOAD; Icache_addr = 64'h7000; mem2proc_response = 4'd7;
        #1;
        n_cmp++; if (Imem_response !== 4'd7 || Dmem_response !== 4'd0) begin n_fail++; $display("FAIL ra_iresp got I%0d D%0d want I7 D0", Imem_response, Dmem_response); end
        exp_q.push_back('{4'd7, 1'b0, 64'h77});
        step();
        idle();
        e = exp_q.pop_front();
        mem2proc_tag = e.tag; mem2proc_data = e.data;
        Dcache_command = BUS_LOAD; Dcache_addr = 64'h8000; mem2proc_response = 4'd7;
        #1;
        n_cmp++; if (Imem_tag !== e.tag || Imem_data !== e.data || Dmem_tag !== 4'd0) begin n_fail++; $display("FAIL ra_iret got I%0d/%h D%0d want I%0d/%h D0", Imem_tag, Imem_data, Dmem_tag, e.tag, e.data); end
        n_cmp++; if (Dmem_response !== 4'd7) begin n_fail++; $display("FAIL ra_dresp got %0d want 7", Dmem_response); end
        exp_q.push_back('{4'd7, 1'b1, 64'h88});
        step();
        idle();
        n_cmp++; if (outstanding_count !== 5'd1) begin n_fail++; $display("FAIL ra_count got %0d want 1", outstanding_count); end
        e = exp_q.pop_front();
        mem2proc_tag = e.tag; mem2proc_data = e.data;
        #1;
        n_cmp++; if (Dmem_tag !== e.tag || Dmem_data !== e.data || Imem_tag !== 4'd0) begin n_fail++; $display("FAIL ra_dret got D%0d/%h I%0d want D%0d/%h I0", Dmem_tag, Dmem_data, Imem_tag, e.tag, e.data); end
        step();
        idle();
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL ra_count0 got %0d want 0", outstanding_count); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            Dcache_command = BUS_LOAD; Dcache_addr = 64'h9000 + 64'(k); mem2proc_response = 4'(11 + k);
            exp_q.push_back('{4'(11 + k), 1'b1, 64'd0});
            step();
        end
        idle();
        n_cmp++; if (outstanding_count !== 5'd3) begin n_fail++; $display("FAIL rm_count3 got %0d want 3", outstanding_count); end
        reset = 1'b1;
        Dcache_command = BUS_LOAD; mem2proc_response = 4'd14;
        #1;
        n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rm_cmd got %0d want 0", proc2mem_command); end
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rm_forced got %0d want 0", outstanding_count); end
        step();
        reset = 1'b0;
        idle();
        exp_q.delete();
        #1;
        n_cmp++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rm_count0 got %0d want 0", outstanding_count); end
        n_cmp++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL rm_tagerr0 got %0b want 0", tag_error); end
        mem2proc_tag = 4'd12; mem2proc_data = 64'hBAD;
        #1;
        n_cmp++; if (Imem_tag !== 4'd0 || Dmem_tag !== 4'd0) begin n_fail++; $display("FAIL rm_ret got I%0d D%0d want 0/0", Imem_tag, Dmem_tag); end
        step();
        idle();
        n_cmp++; if (tag_error !== 1'b1) begin n_fail++; $display("FAIL rm_tagerr1 got %0b want 1", tag_error); end
    endtask

    initial begin
        test_reset();
        test_dcache_load();
        test_starvation();
        test_starve_reject();
        test_store_tag_error();
        test_retire_alloc();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
